// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmitter: state encoding, parity modes
// and the clocks-per-bit calculation.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } tx_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  function automatic int calc_baud_div(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

  function automatic logic parity_bit(input logic [7:0] data, input int mode);
    return (mode == PARITY_ODD) ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake and serial line bundle between a byte source and uart_tx.
interface uart_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, tx, tx_busy, tx_done
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, tx, tx_busy, tx_done
  );
endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period timer: bit_tick is high for one cycle every BAUD_DIV clocks;
// clr restarts the period so the first tick lands BAUD_DIV clocks later.
module uart_baud_gen #(
  parameter int BAUD_DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic bit_tick
);

  localparam int CNT_W = $clog2(BAUD_DIV * 2);

  logic [CNT_W-1:0] baud_cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      baud_cnt <= '0;
    end else if (bit_tick) begin
      baud_cnt <= '0;
    end else begin
      baud_cnt <= baud_cnt + CNT_W'(1);
    end
  end

  assign bit_tick = (baud_cnt == CNT_W'(BAUD_DIV - 1));

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one byte per valid/ready handshake, LSB-first frame with
// optional parity and one or two stop bits; all line/status outputs registered.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 9600,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic      clk,
  input  logic      rst,
  uart_tx_if.slave  bus
);

  localparam int BAUD_DIV = calc_baud_div(CLK_FREQ, BAUD_RATE);

  if (BAUD_DIV < 2) begin : g_bad_div
    $error("uart_tx: BAUD_DIV must be at least 2");
  end
  if (PARITY != PARITY_NONE && PARITY != PARITY_EVEN && PARITY != PARITY_ODD) begin : g_bad_parity
    $error("uart_tx: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end

  tx_state_t  state;
  logic [7:0] shift_reg;
  logic [2:0] bit_cnt;
  logic       par;
  logic       line;
  logic       ready;
  logic       busy;
  logic       done;
  logic       accept;
  logic       bit_tick;

  assign accept = bus.tx_valid & ready;

  uart_baud_gen #(.BAUD_DIV(BAUD_DIV)) u_baud_gen (
    .clk      (clk),
    .rst      (rst),
    .clr      (accept),
    .bit_tick (bit_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      par       <= 1'b0;
      line      <= 1'b1;
      ready     <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            shift_reg <= bus.tx_data;
            par       <= parity_bit(bus.tx_data, PARITY);
            bit_cnt   <= '0;
            line      <= 1'b0;
            ready     <= 1'b0;
            busy      <= 1'b1;
            state     <= S_START;
          end
        end
        S_START: begin
          if (bit_tick) begin
            line  <= shift_reg[0];
            state <= S_DATA;
          end
        end
        S_DATA: begin
          if (bit_tick) begin
            if (bit_cnt == 3'd7) begin
              bit_cnt <= '0;
              if (PARITY != PARITY_NONE) begin
                line  <= par;
                state <= S_PARITY;
              end else begin
                line  <= 1'b1;
                state <= S_STOP;
              end
            end else begin
              bit_cnt   <= bit_cnt + 3'd1;
              line      <= shift_reg[1];
              shift_reg <= {1'b0, shift_reg[7:1]};
            end
          end
        end
        S_PARITY: begin
          if (bit_tick) begin
            line    <= 1'b1;
            bit_cnt <= '0;
            state   <= S_STOP;
          end
        end
        S_STOP: begin
          // bit_cnt counts completed stop-bit periods
          if (bit_tick) begin
            if (bit_cnt == 3'(STOP_BITS - 1)) begin
              bit_cnt <= '0;
              ready   <= 1'b1;
              busy    <= 1'b0;
              done    <= 1'b1;
              state   <= S_IDLE;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
        end
        default: begin
          line  <= 1'b1;
          ready <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.tx       = line;
  assign bus.tx_ready = ready;
  assign bus.tx_busy  = busy;
  assign bus.tx_done  = done;

endmodule
